data_memory_bytelane: RTL and testbench
=======================================

// Module: data_memory_bytelane
// PURPOSE
//  Parametrised MIPS data memory: word-organised, big-endian storage with byte/half/word access,
//  sign or zero extension on loads, registered 1-cycle read and a post-reset clearing sweep.
//  Sits in the MEM stage behind the ALU address; its rdata feeds the write-back mux.
// PARAMETERS
//  DEPTH_WORDS  256  storage depth in 32-bit words; power of 2, >=4
//  IDX_W        $clog2(DEPTH_WORDS)  derived word-index width; not overridden
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   reset, synchronous, active-low
//  MemRead    in   1   read request, sampled on posedge
//  MemWrite   in   1   write request, sampled on posedge
//  size       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  unsigned_ld in  1   1 = zero-extend byte/half loads, 0 = sign-extend
//  address    in   32  byte address; bits [IDX_W+1:0] used, upper bits ignored (wrap)
//  wdata      in   32  store data; sb uses [7:0], sh uses [15:0], sw uses [31:0]
//  rdata      out  32  load data, registered
//  rvalid     out  1   1-cycle pulse: rdata updated by the previous cycle's read
//  busy       out  1   1 while in reset or clearing; requests ignored
//  misalign   out  1   1-cycle pulse on a misaligned access (feature-dependent)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state<=CLEAR, clr_ptr<=0; rdata=0, rvalid=0, misalign=0, busy=1.
//  - FSM CLEAR: each cycle with rst=1 writes 0 to word clr_ptr, clr_ptr++; after word
//    DEPTH_WORDS-1 -> READY. Takes DEPTH_WORDS cycles; busy=1 throughout; MemRead/MemWrite ignored.
//  - Reset mid-sweep: sweep restarts at word 0 after rst returns to 1.
//  - READY: busy=0; requests accepted every cycle, no back-pressure.
//  - Addressing: word = address[IDX_W+1:2], off = address[1:0]; addresses >= 4*DEPTH_WORDS wrap.
//  - Byte lanes big-endian: off 0 = bits [31:24], off 3 = bits [7:0].
//  - Stores: sw writes all 4 lanes; sh writes lanes off,off+1 with wdata[15:8],[7:0];
//    sb writes lane off with wdata[7:0]. Other lanes unchanged. Visible to reads next cycle.
//  - Loads: 1-cycle latency. Lane(s) selected by off, right-justified, extended per unsigned_ld;
//    word loads ignore unsigned_ld. rdata holds its value until the next accepted read.
//  - MemRead & MemWrite same cycle, same word: read-before-write; rdata returns old contents,
//    write still performed.
//  - rvalid=1 exactly the cycle after an accepted read; 0 otherwise (incl. after writes).
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: misaligned = (half & off[0]) | (word & off!=0). Such an access
//   is suppressed (no lanes written, rdata unchanged); misalign=1 the following cycle; rvalid
//   still pulses for a suppressed read.
//  DMEM_ALIGN_CHECK_EN undefined: misalign tied 0; off[0] forced 0 for half, off forced 0 for
//   word, access performed at the aligned address.
// TESTING
//  1. Release rst, poll busy -> busy=1 for exactly 256 cycles, then 0; lw any word -> 0x00000000.
//  2. sw 0x11223344 @0x10; lb @0x10,0x13 signed -> 0x00000011, 0x00000044; lh @0x12 -> 0x00003344.
//  3. sb 0xF0 @0x21 onto word 0; lb signed @0x21 -> 0xFFFFFFF0; lbu -> 0x000000F0; lw @0x20 -> 0x00F00000.
//  4. sw 0xAAAAAAAA @0x40 then MemRead+sw 0x55555555 same cycle @0x40 -> rdata 0xAAAAAAAA;
//     next lw -> 0x55555555. lw @0x400+0x40 wraps -> same word.
//  5. Assert rst at clr_ptr=100, release -> busy stays 1 for full 256 cycles; prior data cleared.
//  6. lw @0x42: with DMEM_ALIGN_CHECK_EN -> misalign=1, rvalid=1, rdata unchanged;
//     without -> misalign=0, rdata = word @0x40.

Source files
------------

// File: rtl/data_memory_bytelane_if.sv
// data_memory_bytelane_if
//   Request/response bundle between the MEM stage and the byte-lane data memory.
//   master : MemRead, MemWrite, size, unsigned_ld, address, wdata driven;
//            rdata, rvalid, busy, misalign observed.
//   slave  : the memory side of the same signals.
interface data_memory_bytelane_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        misalign;

  modport master (
    output MemRead, MemWrite, size, unsigned_ld, address, wdata,
    input  rdata, rvalid, busy, misalign
  );

  modport slave (
    input  MemRead, MemWrite, size, unsigned_ld, address, wdata,
    output rdata, rvalid, busy, misalign
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   Word-organised, big-endian MIPS data memory with byte/half/word stores,
//   sign/zero-extended loads, a registered 1-cycle read path and a clearing
//   sweep that zeroes every word after reset.
//
//   Ports:
//     clk  - clock, all state updates on posedge
//     rst  - synchronous, active-low reset
//     bus  - data_memory_bytelane_if.slave:
//            MemRead/MemWrite/size/unsigned_ld/address/wdata in,
//            rdata (registered), rvalid (pulse), busy, misalign (pulse) out
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN
//     defined   - misaligned half/word accesses are suppressed and flagged
//     undefined - misalign stays 0 and low address bits are forced to alignment
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   CLEAR   | post-reset sweep, one word zeroed per cycle, busy=1
//   READY   | requests accepted every cycle
module data_memory_bytelane #(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  data_memory_bytelane_if.slave      bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        off;
  logic [1:0]        eff_off;
  logic              is_byte, is_half;
  logic              mis;

  logic [31:0]       cur_word;
  logic [31:0]       wr_mask;
  logic [31:0]       wr_shifted;
  logic [31:0]       merged_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_word_d;

  // Upper address bits are intentionally ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[31:IDX_W+2];

  assign word_idx = bus.address[IDX_W+1:2];
  assign off      = bus.address[1:0];
  assign is_byte  = (bus.size == 2'b00);
  assign is_half  = (bus.size == 2'b01);

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis     = (is_half & off[0]) | (!is_byte && !is_half && (off != 2'b00));
  assign eff_off = off;
`else
  assign mis     = 1'b0;
  assign eff_off = is_byte ? off : (is_half ? {off[1], 1'b0} : 2'b00);
`endif

  assign cur_word = mem_q[word_idx];

  // Big-endian lanes: offset 0 is bits [31:24], so a lane sits 8*(3-off)
  // bits up from bit 0, and 3-off is simply ~off for a 2-bit offset.
  always_comb begin
    wr_mask    = 32'hFFFF_FFFF;
    wr_shifted = bus.wdata;
    rd_byte    = 8'(cur_word >> {~eff_off, 3'b000});
    rd_half    = eff_off[1] ? cur_word[15:0] : cur_word[31:16];
    load_val   = cur_word;
    if (is_byte) begin
      wr_mask    = 32'h0000_00FF << {~eff_off, 3'b000};
      wr_shifted = {24'h0, bus.wdata[7:0]} << {~eff_off, 3'b000};
      load_val   = bus.unsigned_ld ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      wr_mask    = 32'h0000_FFFF << {~eff_off[1], 4'b0000};
      wr_shifted = {16'h0, bus.wdata[15:0]} << {~eff_off[1], 4'b0000};
      load_val   = bus.unsigned_ld ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
    end
    merged_word = (cur_word & ~wr_mask) | (wr_shifted & wr_mask);
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = word_idx;
    mem_word_d = merged_word;
    case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_idx    = clr_ptr_q;
        mem_word_d = 32'h0;
        clr_ptr_d  = clr_ptr_q + IDX_W'(1);
        if (clr_ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.MemRead || bus.MemWrite) misalign_d = mis;
        // Read samples the pre-write contents, giving read-before-write
        // when a read and a write hit the same word in one cycle.
        if (bus.MemRead) begin
          rvalid_d = 1'b1;
          if (!mis) rdata_d = load_val;
        end
        if (bus.MemWrite && !mis) mem_we = 1'b1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage has no reset of its own; the sweep zeroes it once rst is released.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[mem_idx] <= mem_word_d;
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;
  assign bus.busy     = !rst || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  data_memory_bytelane_if bus ();

  data_memory_bytelane #(.DEPTH_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request for one clock; returns #1 after the sampling edge so
  // registered outputs reflect this request.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.size        = sz;
    bus.unsigned_ld = uns;
    bus.address     = addr;
    bus.wdata       = wd;
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // Counts cycles with busy=1 starting from the current one; also reports
  // whether rvalid ever rose while busy. Bounded so it always returns.
  task automatic sweep_count(output int n, output bit rv_seen);
    n = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!bus.busy) break;
      n++;
      @(posedge clk);
      #1;
      if (bus.rvalid) rv_seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    bit rv;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0); else n_pass++;
    n_total++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); else n_pass++;
    n_total++; if (bus.misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", bus.misalign); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else n_pass++;
    rst = 1'b1;
    sweep_count(n, rv);
    n_total++; if (n !== 256) $display("FAIL sweep_len: got %0d want 256", n); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0000, 32'h0);
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL lw_after_clear: got %h want %h", bus.rdata, 32'h0); else n_pass++;
    n_total++; if (bus.rvalid !== 1'b1) $display("FAIL rvalid_pulse: got %b want 1", bus.rvalid); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_03FC, 32'h0);
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL lw_last_cleared: got %h want %h", bus.rdata, 32'h0); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.rvalid !== 1'b0) $display("FAIL rvalid_idle: got %b want 0", bus.rvalid); else n_pass++;
  endtask

  task automatic test_word_byte;
    access(0, 1, 2'b10, 0, 32'h0000_0010, 32'h1122_3344);
    n_total++; if (bus.rvalid !== 1'b0) $display("FAIL rvalid_after_sw: got %b want 0", bus.rvalid); else n_pass++;
    access(1, 0, 2'b00, 0, 32'h0000_0010, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_0011) $display("FAIL lb_10: got %h want %h", bus.rdata, 32'h0000_0011); else n_pass++;
    access(1, 0, 2'b00, 0, 32'h0000_0013, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_0044) $display("FAIL lb_13: got %h want %h", bus.rdata, 32'h0000_0044); else n_pass++;
    access(1, 0, 2'b01, 0, 32'h0000_0012, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_3344) $display("FAIL lh_12: got %h want %h", bus.rdata, 32'h0000_3344); else n_pass++;
    access(1, 0, 2'b01, 0, 32'h0000_0010, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_1122) $display("FAIL lh_10: got %h want %h", bus.rdata, 32'h0000_1122); else n_pass++;
    access(0, 1, 2'b10, 0, 32'h0000_0014, 32'h80FF_7F01);
    access(1, 0, 2'b00, 0, 32'h0000_0015, 32'h0);
    n_total++; if (bus.rdata !== 32'hFFFF_FFFF) $display("FAIL lb_15_sign: got %h want %h", bus.rdata, 32'hFFFF_FFFF); else n_pass++;
    access(1, 0, 2'b00, 1, 32'h0000_0016, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_007F) $display("FAIL lbu_16: got %h want %h", bus.rdata, 32'h0000_007F); else n_pass++;
    access(1, 0, 2'b01, 0, 32'h0000_0014, 32'h0);
    n_total++; if (bus.rdata !== 32'hFFFF_80FF) $display("FAIL lh_14_sign: got %h want %h", bus.rdata, 32'hFFFF_80FF); else n_pass++;
    access(1, 0, 2'b01, 1, 32'h0000_0014, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_80FF) $display("FAIL lhu_14: got %h want %h", bus.rdata, 32'h0000_80FF); else n_pass++;
    access(1, 0, 2'b10, 1, 32'h0000_0014, 32'h0);
    n_total++; if (bus.rdata !== 32'h80FF_7F01) $display("FAIL lw_14_uns: got %h want %h", bus.rdata, 32'h80FF_7F01); else n_pass++;
  endtask

  task automatic test_store_lanes;
    access(0, 1, 2'b00, 0, 32'h0000_0021, 32'hABCD_EFF0);
    access(1, 0, 2'b00, 0, 32'h0000_0021, 32'h0);
    n_total++; if (bus.rdata !== 32'hFFFF_FFF0) $display("FAIL lb_21: got %h want %h", bus.rdata, 32'hFFFF_FFF0); else n_pass++;
    access(1, 0, 2'b00, 1, 32'h0000_0021, 32'h0);
    n_total++; if (bus.rdata !== 32'h0000_00F0) $display("FAIL lbu_21: got %h want %h", bus.rdata, 32'h0000_00F0); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);
    n_total++; if (bus.rdata !== 32'h00F0_0000) $display("FAIL lw_20_sb: got %h want %h", bus.rdata, 32'h00F0_0000); else n_pass++;
    access(0, 1, 2'b01, 0, 32'h0000_0022, 32'h1234_BEEF);
    n_total++; if (bus.rdata !== 32'h00F0_0000) $display("FAIL rdata_hold: got %h want %h", bus.rdata, 32'h00F0_0000); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);
    n_total++; if (bus.rdata !== 32'h00F0_BEEF) $display("FAIL lw_20_sh: got %h want %h", bus.rdata, 32'h00F0_BEEF); else n_pass++;
    access(0, 1, 2'b00, 0, 32'h0000_0020, 32'h0000_0077);
    access(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0);
    n_total++; if (bus.rdata !== 32'h77F0_BEEF) $display("FAIL lw_20_sb0: got %h want %h", bus.rdata, 32'h77F0_BEEF); else n_pass++;
  endtask

  task automatic test_back_to_back;
    access(0, 1, 2'b10, 0, 32'h0000_0040, 32'hAAAA_AAAA);
    access(1, 1, 2'b10, 0, 32'h0000_0040, 32'h5555_5555);
    n_total++; if (bus.rdata !== 32'hAAAA_AAAA) $display("FAIL rbw_old: got %h want %h", bus.rdata, 32'hAAAA_AAAA); else n_pass++;
    n_total++; if (bus.rvalid !== 1'b1) $display("FAIL rbw_rvalid: got %b want 1", bus.rvalid); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL rbw_new: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0000, 32'h0);
    access(1, 0, 2'b10, 0, 32'h0000_0440, 32'h0);
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL wrap_440: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
    access(1, 0, 2'b10, 0, 32'hFFFF_F040, 32'h0);
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL wrap_hi: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
  endtask

  task automatic test_misalign;
    access(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    access(1, 0, 2'b10, 0, 32'h0000_0042, 32'h0);
    n_total++; if (bus.rvalid !== 1'b1) $display("FAIL mis_lw_rvalid: got %b want 1", bus.rvalid); else n_pass++;
`ifdef DMEM_ALIGN_CHECK_EN
    n_total++; if (bus.misalign !== 1'b1) $display("FAIL mis_lw_flag: got %b want 1", bus.misalign); else n_pass++;
    n_total++; if (bus.rdata !== 32'h1122_3344) $display("FAIL mis_lw_rdata: got %h want %h", bus.rdata, 32'h1122_3344); else n_pass++;
`else
    n_total++; if (bus.misalign !== 1'b0) $display("FAIL mis_lw_flag: got %b want 0", bus.misalign); else n_pass++;
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL mis_lw_rdata: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
`endif
    @(posedge clk); #1;
    n_total++; if (bus.misalign !== 1'b0) $display("FAIL mis_pulse_end: got %b want 0", bus.misalign); else n_pass++;
    access(0, 1, 2'b10, 0, 32'h0000_0041, 32'h9999_9999);
    access(1, 0, 2'b10, 0, 32'h0000_0040, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL mis_sw_suppr: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
`else
    n_total++; if (bus.rdata !== 32'h9999_9999) $display("FAIL mis_sw_forced: got %h want %h", bus.rdata, 32'h9999_9999); else n_pass++;
`endif
    access(1, 0, 2'b01, 0, 32'h0000_0011, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    n_total++; if (bus.rdata !== 32'h5555_5555) $display("FAIL mis_lh: got %h want %h", bus.rdata, 32'h5555_5555); else n_pass++;
`else
    n_total++; if (bus.rdata !== 32'h0000_1122) $display("FAIL mis_lh: got %h want %h", bus.rdata, 32'h0000_1122); else n_pass++;
`endif
  endtask

  task automatic test_reset_midsweep;
    int n;
    bit rv;
    access(0, 1, 2'b10, 0, 32'h0000_0080, 32'h1234_5678);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    // Requests held active through the sweep must all be ignored.
    bus.MemRead     = 1'b1;
    bus.MemWrite    = 1'b1;
    bus.size        = 2'b10;
    bus.address     = 32'h0000_0080;
    bus.wdata       = 32'hDEAD_BEEF;
    sweep_count(n, rv);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    n_total++; if (n !== 256) $display("FAIL midsweep_len: got %0d want 256", n); else n_pass++;
    n_total++; if (rv !== 1'b0) $display("FAIL busy_rvalid: got %b want 0", rv); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0080, 32'h0);
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL midsweep_cleared: got %h want %h", bus.rdata, 32'h0); else n_pass++;
    access(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0);
    n_total++; if (bus.rdata !== 32'h0) $display("FAIL midsweep_cleared2: got %h want %h", bus.rdata, 32'h0); else n_pass++;
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst             = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.size        = 2'b10;
    bus.unsigned_ld = 1'b0;
    bus.address     = 32'h0;
    bus.wdata       = 32'h0;
    test_reset();
    test_word_byte();
    test_store_lanes();
    test_back_to_back();
    test_misalign();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
